logic_arbiter: RTL

LOGIC_ARBITER -- requirements
Module: logic_arbiter

---
 rtl/logic_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/logic_arbiter.sv
// logic_arbiter: two requesters share one bitwise logic unit (AND/OR/XOR/NOT A).
// A round-robin arbiter picks one request in IDLE, the operands are captured,
// the result is computed in EXEC and then held in RESP until it is consumed.
//
// Handshake rule (both request ports and the response port): a transfer happens
// on a rising clk edge where valid and ready are both high; the producer holds
// its valid and payload steady until that edge. Request readies are
// combinational and only ever high in IDLE. rsp_valid and the response payload
// are registered and stay frozen while rsp_ready is low.
module logic_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [1:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_id;

    logic             grant_id;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    // Round-robin winner: a lone requester always wins; on contention the one not granted last wins
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;
    assign dbg_state  = state;

    // Route the winning requester's payload toward the capture registers
    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant_id) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // Shared logic unit, fed only from captured operands so late input changes cannot leak in
    always_comb begin
        result = '0;
        case (cap_op)
            2'b00:   result = cap_a & cap_b;
            2'b01:   result = cap_a | cap_b;
            2'b10:   result = cap_a ^ cap_b;
            default: result = ~cap_a;
        endcase
    end

    // Control FSM with registered response outputs; reset drops any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cap_op     <= 2'b00;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_op     <= sel_op;
                        cap_a      <= sel_a;
                        cap_b      <= sel_b;
                        cap_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= result;
                    rsp_zero  <= (result == '0);
                    rsp_id    <= cap_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
